// File: rtl/niosii_soc_div_pkg.sv
// Shared types and constants for the Nios II divide cell.
// State encoding, default width and divide-by-zero quotient.
package niosii_soc_div_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] ZERO_DIV_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/niosii_soc_nios2_div_step.sv
// One restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, emit one quotient bit.
module niosii_soc_nios2_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] pr_i,
  input  logic         msb_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] pr_o,
  output logic         q_o
);

  logic [W:0] pr_sh;
  logic [W:0] diff;

  // pr < divisor on entry, so the W+1-bit difference cannot wrap
  always_comb begin
    pr_sh = {pr_i, msb_i};
    diff  = pr_sh - {1'b0, dvs_i};
    q_o   = (pr_sh >= {1'b0, dvs_i});
    pr_o  = q_o ? diff[W-1:0] : pr_sh[W-1:0];
  end

endmodule

// File: rtl/niosii_soc_nios2_div_cell.sv
// Iterative radix-2 signed/unsigned divider backing div/divu.
// One quotient bit per cycle, sign fix-up, one-cycle done pulse.
module niosii_soc_nios2_div_cell
  import niosii_soc_div_pkg::*;
#(
  parameter int DATA_WIDTH = niosii_soc_div_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] ZERO_DIV_QUOT = '1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] A_div_src1,
  input  logic [DATA_WIDTH-1:0] A_div_src2,
  input  logic                  A_div_signed,
  input  logic                  A_div_start,
  output logic                  A_div_busy,
  output logic                  A_div_done,
  output logic [DATA_WIDTH-1:0] A_div_quot,
  output logic [DATA_WIDTH-1:0] A_div_rem,
  output logic                  A_div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = clog2(W);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  pr_q, pr_d;
  logic          sa_q, sa_d;
  logic          sb_q, sb_d;
  logic          zero_q, zero_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          done_q, done_d;
  logic          bz_q, bz_d;

  logic [W-1:0]  pr_step;
  logic          q_bit;

  niosii_soc_nios2_div_step #(
    .W(W)
  ) u_step (
    .pr_i (pr_q),
    .msb_i(dvd_q[W-1]),
    .dvs_i(dvs_q),
    .pr_o (pr_step),
    .q_o  (q_bit)
  );

  // Next-state: dvd_q doubles as dividend shifter and quotient
  // collector; on divide-by-zero it keeps the raw src1 for rem.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    bz_d    = bz_q;
    unique case (state_q)
      IDLE: begin
        if (A_div_start) begin
          sa_d   = A_div_signed & A_div_src1[W-1];
          sb_d   = A_div_signed & A_div_src2[W-1];
          zero_d = (A_div_src2 == '0);
          dvd_d  = (zero_d || !sa_d) ? A_div_src1 : -A_div_src1;
          dvs_d  = sb_d ? -A_div_src2 : A_div_src2;
          pr_d   = '0;
          cnt_d  = CW'(W - 1);
          bz_d   = 1'b0;
          state_d = zero_d ? FIX : CALC;
        end
      end
      CALC: begin
        pr_d  = pr_step;
        dvd_d = {dvd_q[W-2:0], q_bit};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        if (zero_q) begin
          quot_d = ZERO_DIV_QUOT;
          rem_d  = dvd_q;
          bz_d   = 1'b1;
        end else begin
          quot_d = (sa_q ^ sb_q) ? -dvd_q : dvd_q;
          rem_d  = sa_q ? -pr_q : pr_q;
        end
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      bz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      bz_q    <= bz_d;
    end
  end

  assign A_div_busy    = (state_q != IDLE);
  assign A_div_done    = done_q;
  assign A_div_quot    = quot_q;
  assign A_div_rem     = rem_q;
  assign A_div_by_zero = bz_q;

endmodule

// File: doc/niosii_soc_nios2_div_cell.md
Name: niosii_soc_nios2_div_cell

Overview:
Iterative radix-2 integer divider cell. It is the inverse-operation companion to the Nios II multiply cell, and it backs the div/divu instructions in the A stage.
- Accepts dividend and divisor with a start pulse.
- Computes quotient and remainder one bit per cycle, with signed or unsigned semantics.
- Returns results with a one-cycle done pulse. Results are held until the next accepted start.

Parameters:
DATA_WIDTH, 32, operand/result width in bits (W).
ZERO_DIV_QUOT, all-ones of W bits, quotient returned on divide-by-zero.

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  synchronous, active-low reset
A_div_src1  in  W  dividend
A_div_src2  in  W  divisor
A_div_signed  in  1  1 = two's-complement (div), 0 = unsigned (divu); sampled with start
A_div_start  in  1  request; accepted only in IDLE
A_div_busy  out  1  high whenever state != IDLE
A_div_done  out  1  one-cycle pulse; results valid from this cycle on
A_div_quot  out  W  quotient
A_div_rem  out  W  remainder
A_div_by_zero  out  1  divisor was zero for the last accepted operation

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-low on reset_n, sampled on the rising edge.
- Reset values: state IDLE; busy=0, done=0, quot=0, rem=0, by_zero=0, iteration counter=0.
- Reset mid-operation: at the next edge the cell returns to IDLE with all outputs at reset values. The in-flight result is discarded and no done pulse is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 (edge 0):
  - latch signed, and the operand signs sa = signed & src1[W-1], sb = signed & src2[W-1];
  - load magnitudes |src1| and |src2| (negate when the sign is set);
  - clear the partial remainder; counter = W-1.
  - Next state is CALC, or FIX directly if src2 == 0.
- CALC, one iteration per cycle:
  - partial remainder pr' = {pr, dividend MSB}; dividend shifts left;
  - if pr' >= divisor then pr' -= divisor and shift in quotient bit 1, else 0;
  - the compare/subtract uses a W+1-bit difference;
  - counter decrements; after the counter==0 iteration, go to FIX.
  - Exactly W CALC cycles.
- FIX, normal case:
  - quot = (sa^sb) ? -q : q; rem = sa ? -pr : pr (truncation toward zero, remainder takes the dividend's sign);
  - register the outputs and go to DONE.
- FIX, divide-by-zero case: quot = ZERO_DIV_QUOT, rem = original src1 unmodified, by_zero=1.
- DONE: done=1 for this cycle only, then IDLE. Outputs hold until the next accepted start, which clears by_zero.
- Latency: the done cycle is W+2 cycles after the start-sample cycle (34 for W=32). For divide-by-zero it is 2 cycles after.
- Signed overflow, 0x80000000 / -1: magnitude path yields quot=0x80000000, rem=0. No special case and no trap.
- Start outside IDLE is ignored. Operand inputs are don't-care except in the start cycle.
- Start in the same cycle as reset_n=0: reset wins.
- Back-to-back: a start presented in the DONE cycle is ignored. The earliest accepted restart is the cycle after DONE (IDLE).
- All arithmetic is modulo 2^W. Negation is two's complement.

Decomposition:
- Shared package niosii_soc_div_pkg holds:
  - DATA_WIDTH default;
  - state enum (IDLE, CALC, FIX, DONE);
  - ZERO_DIV_QUOT constant;
  - counter width function clog2(W).
- One natural sub-module, niosii_soc_nios2_div_step: purely combinational single iteration. Inputs are pr, dividend MSB and divisor; outputs are the next pr and the quotient bit. It is reusable if a radix-4 (two steps per cycle) variant is later built.

Test Plan:
- Unsigned 100/7, signed=0 -> quot=14, rem=2, by_zero=0; done exactly 34 cycles after start; busy high for cycles 1..34.
- Signed -7/2 (0xFFFFFFF9/0x00000002) -> quot=0xFFFFFFFD, rem=0xFFFFFFFF. Signed 7/-2 -> quot=0xFFFFFFFD, rem=0x00000001.
- 0x80000000/0xFFFFFFFF: signed -> quot=0x80000000, rem=0. Unsigned -> quot=0, rem=0x80000000.
- 5/0, either mode -> quot=0xFFFFFFFF, rem=5, by_zero=1, done 2 cycles after start. A following 9/3 -> quot=3, rem=0, by_zero=0.
- reset_n=0 at CALC cycle 10 -> next cycle busy=0, outputs 0, no done. A new start 12/5 afterwards -> quot=2, rem=2 at cycle 34.
- Start pulses during busy and in the DONE cycle are ignored (results unchanged). A start in the cycle after DONE is accepted. Random signed/unsigned operands are checked against a reference model.
